// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 core data-memory path.
//   DMEM_AW / DMEM_WW : default data-memory address and word widths.
//   rsp_owner_t       : who receives the read data returned by DMEM one
//                       cycle after a read is issued.
package swt16_pkg;

    localparam int DMEM_AW = 12;
    localparam int DMEM_WW = 16;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_PIPE = 2'd1,
        RSP_DBG  = 2'd2
    } rsp_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the pipeline
// load/store path and a debug/DMA requester. The pipeline has fixed priority;
// debug is served in cycles where the pipe makes no request.
//
// Optional feature macro: DMEM_ARB_STARVE_GUARD_EN
//   When defined, a starvation counter forces a debug slot (and stalls the
//   pipe for that cycle) after STARVE_LIMIT consecutive busy pipe cycles
//   with debug waiting. When undefined, debug can wait indefinitely and
//   out_pipe_stall is always 0.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   in_pipe_rd_req/wr_req        pipeline load/store this cycle (both = store)
//   in_pipe_addr/wr_word         pipeline address and store data
//   out_pipe_stall               pipe must hold and re-present its request
//   out_pipe_rd_word/rd_valid    load data, cycle after an accepted load
//   in_dbg_req/we/addr/wr_word   debug request, held until out_dbg_gnt
//   out_dbg_gnt                  debug access issued this cycle
//   out_dbg_rd_word/rd_valid     debug read data, cycle after a read grant
//   out_dmem_rd_addr/wr_addr/wr_word/wr_en  DMEM macro port
//   in_dmem_rd_word              DMEM read data, 1 cycle after address
//
// Handshake: the debug side is request/grant. in_dbg_req rises with stable
// we/addr/data and stays high until the cycle out_dbg_gnt is 1; that cycle
// is the access. Read data comes back on out_dbg_rd_valid the next cycle.
module dmem_arbiter
    import swt16_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH  = DMEM_AW,
    parameter int DMEM_WORD_WIDTH  = DMEM_WW,
    parameter int STARVE_LIMIT     = 8,
    parameter int STARVE_CNT_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_pipe_rd_req,
    input  logic                       in_pipe_wr_req,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_pipe_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_pipe_wr_word,
    output logic                       out_pipe_stall,
    output logic [DMEM_WORD_WIDTH-1:0] out_pipe_rd_word,
    output logic                       out_pipe_rd_valid,
    input  logic                       in_dbg_req,
    input  logic                       in_dbg_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dbg_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dbg_wr_word,
    output logic                       out_dbg_gnt,
    output logic [DMEM_WORD_WIDTH-1:0] out_dbg_rd_word,
    output logic                       out_dbg_rd_valid,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
    output logic                       out_dmem_wr_en,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word
);

    // Elaboration-time range check of the starvation limit.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2 ** STARVE_CNT_WIDTH) - 1) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT out of range for STARVE_CNT_WIDTH");
    end

    rsp_owner_t rsp_owner;
    rsp_owner_t rsp_owner_next;
    logic       pipe_busy;
    logic       pipe_own;
    logic       dbg_own;
    logic       force_slot;

    assign pipe_busy = in_pipe_rd_req | in_pipe_wr_req;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT_CNT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    logic [STARVE_CNT_WIDTH-1:0] starve_cnt;

    // Forced slot only while debug is actually waiting behind a busy pipe.
    assign force_slot = in_dbg_req & pipe_busy & (starve_cnt == LIMIT_CNT);

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!in_dbg_req || dbg_own) begin
            starve_cnt <= '0;
        end else if (pipe_busy && starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_slot = 1'b0;
`endif

    assign pipe_own = pipe_busy & ~force_slot;
    assign dbg_own  = in_dbg_req & (~pipe_busy | force_slot);

    always_comb begin
        rsp_owner_next    = RSP_NONE;
        out_pipe_stall    = 1'b0;
        out_pipe_rd_word  = '0;
        out_pipe_rd_valid = 1'b0;
        out_dbg_gnt       = 1'b0;
        out_dbg_rd_word   = '0;
        out_dbg_rd_valid  = 1'b0;
        out_dmem_rd_addr  = '0;
        out_dmem_wr_addr  = '0;
        out_dmem_wr_word  = '0;
        out_dmem_wr_en    = 1'b0;

        // Everything is held at 0 during reset, including the response of a
        // read issued just before reset.
        if (!reset) begin
            if (pipe_own) begin
                // A simultaneous load+store is a store; no load data returns.
                if (in_pipe_wr_req) begin
                    out_dmem_wr_addr = in_pipe_addr;
                    out_dmem_wr_word = in_pipe_wr_word;
                    out_dmem_wr_en   = 1'b1;
                end else begin
                    out_dmem_rd_addr = in_pipe_addr;
                    rsp_owner_next   = RSP_PIPE;
                end
            end else if (dbg_own) begin
                out_dbg_gnt = 1'b1;
                if (in_dbg_we) begin
                    out_dmem_wr_addr = in_dbg_addr;
                    out_dmem_wr_word = in_dbg_wr_word;
                    out_dmem_wr_en   = 1'b1;
                end else begin
                    out_dmem_rd_addr = in_dbg_addr;
                    rsp_owner_next   = RSP_DBG;
                end
            end

            out_pipe_stall = force_slot;

            case (rsp_owner)
                RSP_PIPE: begin
                    out_pipe_rd_word  = in_dmem_rd_word;
                    out_pipe_rd_valid = 1'b1;
                end
                RSP_DBG: begin
                    out_dbg_rd_word  = in_dmem_rd_word;
                    out_dbg_rd_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_owner <= RSP_NONE;
        end else begin
            rsp_owner <= rsp_owner_next;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_pipe_rd_req, in_pipe_wr_req;
    logic [11:0] in_pipe_addr;
    logic [15:0] in_pipe_wr_word;
    logic        out_pipe_stall;
    logic [15:0] out_pipe_rd_word;
    logic        out_pipe_rd_valid;
    logic        in_dbg_req, in_dbg_we;
    logic [11:0] in_dbg_addr;
    logic [15:0] in_dbg_wr_word;
    logic        out_dbg_gnt;
    logic [15:0] out_dbg_rd_word;
    logic        out_dbg_rd_valid;
    logic [11:0] out_dmem_rd_addr, out_dmem_wr_addr;
    logic [15:0] out_dmem_wr_word;
    logic        out_dmem_wr_en;
    logic [15:0] in_dmem_rd_word;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .STARVE_LIMIT(8), .STARVE_CNT_WIDTH(4)
    ) dut (
        .clock(clock), .reset(reset),
        .in_pipe_rd_req(in_pipe_rd_req), .in_pipe_wr_req(in_pipe_wr_req),
        .in_pipe_addr(in_pipe_addr), .in_pipe_wr_word(in_pipe_wr_word),
        .out_pipe_stall(out_pipe_stall), .out_pipe_rd_word(out_pipe_rd_word),
        .out_pipe_rd_valid(out_pipe_rd_valid),
        .in_dbg_req(in_dbg_req), .in_dbg_we(in_dbg_we), .in_dbg_addr(in_dbg_addr),
        .in_dbg_wr_word(in_dbg_wr_word), .out_dbg_gnt(out_dbg_gnt),
        .out_dbg_rd_word(out_dbg_rd_word), .out_dbg_rd_valid(out_dbg_rd_valid),
        .out_dmem_rd_addr(out_dmem_rd_addr), .out_dmem_wr_addr(out_dmem_wr_addr),
        .out_dmem_wr_word(out_dmem_wr_word), .out_dmem_wr_en(out_dmem_wr_en),
        .in_dmem_rd_word(in_dmem_rd_word)
    );

    // Clock
    always #5 clock = ~clock;

    // DMEM macro: 1-cycle synchronous read, write-first on same address.
    logic [15:0] mem [0:4095];
    always @(posedge clock) begin
        if (out_dmem_wr_en) mem[out_dmem_wr_addr] <= out_dmem_wr_word;
        if (out_dmem_wr_en && out_dmem_wr_addr == out_dmem_rd_addr)
            in_dmem_rd_word <= out_dmem_wr_word;
        else
            in_dmem_rd_word <= mem[out_dmem_rd_addr];
    end

    // Debug request must stay high until granted.
    logic dbg_pend = 1'b0;
    always @(posedge clock) begin
        if (!reset && dbg_pend && !in_dbg_req) begin
            $display("FAIL dbg_req_withdrawn at %0t", $time);
            errors++;
        end
        dbg_pend <= in_dbg_req && !out_dbg_gnt && !reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic prd, input logic pwr, input logic [11:0] paddr,
                         input logic [15:0] pwd, input logic dreq, input logic dwe,
                         input logic [11:0] daddr, input logic [15:0] dwd);
        reset = rst; in_pipe_rd_req = prd; in_pipe_wr_req = pwr;
        in_pipe_addr = paddr; in_pipe_wr_word = pwd;
        in_dbg_req = dreq; in_dbg_we = dwe; in_dbg_addr = daddr; in_dbg_wr_word = dwd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst, prd, pwr;
        logic [11:0] paddr;
        logic [15:0] pwd;
        logic        dreq, dwe;
        logic [11:0] daddr;
        logic [15:0] dwd;
        logic        stall, gnt, wen;
        logic [11:0] raddr, waddr;
        logic [15:0] wword;
        logic        prv;
        logic [15:0] prw;
        logic        drv;
        logic [15:0] drw;
    } vec_t;

    vec_t vecs[19];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[12'h010] = 16'hBEEF;
        in_dmem_rd_word = 16'h0;
        drive(1'b1, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
        repeat (2) @(posedge clock);
        #1;

        //           rst   prd   pwr   paddr   pwd       dreq  dwe   daddr   dwd        stall gnt   wen   raddr   waddr   wword     prv   prw       drv   drw
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h020, 16'h1234, 1'b0, 1'b1, 1'b1, 12'h000, 12'h020, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h020, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h020, 12'h000, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1234};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 12'h030, 16'h5A5A, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 12'h000, 12'h030, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 12'h030, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h030, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 16'h5A5A, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 12'h040, 16'h0777, 1'b1, 1'b1, 12'h020, 16'h4321, 1'b0, 1'b0, 1'b1, 12'h000, 12'h040, 16'h0777, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h020, 16'h4321, 1'b0, 1'b1, 1'b1, 12'h000, 12'h020, 16'h4321, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h040, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h040, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0777};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 12'h050, 16'h1111, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 12'h000, 12'h050, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 12'h050, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h050, 12'h000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0000};

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].prd, vecs[i].pwr, vecs[i].paddr, vecs[i].pwd,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
            @(negedge clock);
            chk($sformatf("v%0d stall", i),   32'(out_pipe_stall),    32'(vecs[i].stall));
            chk($sformatf("v%0d gnt", i),     32'(out_dbg_gnt),       32'(vecs[i].gnt));
            chk($sformatf("v%0d wr_en", i),   32'(out_dmem_wr_en),    32'(vecs[i].wen));
            chk($sformatf("v%0d rd_addr", i), 32'(out_dmem_rd_addr),  32'(vecs[i].raddr));
            chk($sformatf("v%0d wr_addr", i), 32'(out_dmem_wr_addr),  32'(vecs[i].waddr));
            chk($sformatf("v%0d wr_word", i), 32'(out_dmem_wr_word),  32'(vecs[i].wword));
            chk($sformatf("v%0d p_rv", i),    32'(out_pipe_rd_valid), 32'(vecs[i].prv));
            chk($sformatf("v%0d p_rw", i),    32'(out_pipe_rd_word),  32'(vecs[i].prw));
            chk($sformatf("v%0d d_rv", i),    32'(out_dbg_rd_valid),  32'(vecs[i].drv));
            chk($sformatf("v%0d d_rw", i),    32'(out_dbg_rd_word),   32'(vecs[i].drw));
            next_cycle();
        end

        // Starvation: pipe loads every cycle for 20 cycles, debug read of 0x020 waiting.
        begin
            logic [11:0] pipe_a;
            logic        got_gnt;
            logic        exp_force;
            logic        prev_force;
            pipe_a = 12'h100;
            got_gnt = 1'b0;
            prev_force = 1'b0;
            for (int c = 0; c < 20; c++) begin
                drive(1'b0, 1'b1, 1'b0, pipe_a, 16'h0, !got_gnt, 1'b0, 12'h020, 16'h0);
                exp_force = GUARD && (c == 8);
                @(negedge clock);
                chk($sformatf("starve c%0d gnt", c),   32'(out_dbg_gnt),    32'(exp_force));
                chk($sformatf("starve c%0d stall", c), 32'(out_pipe_stall), 32'(exp_force));
                chk($sformatf("starve c%0d rd_addr", c), 32'(out_dmem_rd_addr),
                    exp_force ? 32'h020 : 32'(pipe_a));
                chk($sformatf("starve c%0d p_rv", c), 32'(out_pipe_rd_valid),
                    32'((c > 0) && !prev_force));
                chk($sformatf("starve c%0d d_rv", c), 32'(out_dbg_rd_valid), 32'(prev_force));
                if (prev_force)
                    chk("starve dbg data", 32'(out_dbg_rd_word), 32'h4321);
                if (exp_force) got_gnt = 1'b1;
                else pipe_a = pipe_a + 12'h1;
                prev_force = exp_force;
                next_cycle();
            end
            // Pipe goes idle: a still-waiting debug request is granted at once.
            drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, !got_gnt, 1'b0, 12'h020, 16'h0);
            @(negedge clock);
            chk("post-starve gnt", 32'(out_dbg_gnt), 32'(!GUARD));
            chk("post-starve stall", 32'(out_pipe_stall), 32'h0);
            next_cycle();
            idle();
            @(negedge clock);
            chk("post-starve d_rv", 32'(out_dbg_rd_valid), 32'(!GUARD));
            chk("post-starve d_rw", 32'(out_dbg_rd_word), GUARD ? 32'h0 : 32'h4321);
            next_cycle();
        end

        // Reset the cycle after a debug read grant: the response is dropped.
        drive(1'b0, 1'b0, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h020, 16'h0);
        @(negedge clock);
        chk("rst seq gnt", 32'(out_dbg_gnt), 32'h1);
        chk("rst seq rd_addr", 32'(out_dmem_rd_addr), 32'h020);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
        @(negedge clock);
        chk("rst seq d_rv in reset", 32'(out_dbg_rd_valid), 32'h0);
        chk("rst seq d_rw in reset", 32'(out_dbg_rd_word), 32'h0);
        chk("rst seq p_rv in reset", 32'(out_pipe_rd_valid), 32'h0);
        next_cycle();
        idle();
        @(negedge clock);
        chk("rst seq d_rv after", 32'(out_dbg_rd_valid), 32'h0);
        chk("rst seq d_rw after", 32'(out_dbg_rd_word), 32'h0);
        chk("rst seq gnt after", 32'(out_dbg_gnt), 32'h0);
        chk("rst seq wr_en after", 32'(out_dmem_wr_en), 32'h0);
        chk("rst seq rd_addr after", 32'(out_dmem_rd_addr), 32'h0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
